// File: rtl/split_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : split_ram_loader
// Description : Streams RAM_WIDTH words from a valid/ready source into
//               NUM_RAMS banks, address-interleaved (bank 0..N-1 per address).
//               Define SPLIT_RAM_LOADER_CHECKSUM_EN to add a running checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module split_ram_loader #(
    parameter int NUM_RAMS  = 8,
    parameter int RAM_DEPTH = 256,
    parameter int RAM_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [RAM_WIDTH-1:0]         in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [RAM_WIDTH-1:0]         data_wr,
    output logic [NUM_RAMS-1:0]          data_layer_wren,
    output logic [$clog2(RAM_DEPTH)-1:0] addr,
    output logic                         busy,
    output logic                         done
`ifdef SPLIT_RAM_LOADER_CHECKSUM_EN
    ,
    output logic [RAM_WIDTH-1:0]         checksum
`endif
);

    localparam int c_addr_w = $clog2(RAM_DEPTH);
    localparam int c_bank_w = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;

    localparam logic [c_bank_w-1:0] c_last_bank = c_bank_w'(NUM_RAMS - 1);
    localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(RAM_DEPTH - 1);
    localparam logic [NUM_RAMS-1:0] c_wren_one  = NUM_RAMS'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_bank_w-1:0]   r_bank_cnt;
    logic [c_addr_w-1:0]   r_addr_cnt;
    logic [RAM_WIDTH-1:0]  r_data_wr;
    logic [c_addr_w-1:0]   r_addr;
    logic [NUM_RAMS-1:0]   r_wren;
    logic                  r_busy;
    logic                  r_done;

    logic w_last_bank;
    logic w_last_addr;
    logic w_accept;

    assign w_last_bank = (r_bank_cnt == c_last_bank);
    assign w_last_addr = (r_addr_cnt == c_last_addr);
    // Abort wins over a simultaneous handshake: the word is dropped.
    assign w_accept    = (r_state == S_LOAD) && in_valid && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_bank_cnt <= '0;
            r_addr_cnt <= '0;
            r_data_wr  <= '0;
            r_addr     <= '0;
            r_wren     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wren <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_busy     <= 1'b1;
                        r_bank_cnt <= '0;
                        r_addr_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_bank_cnt <= '0;
                        r_addr_cnt <= '0;
                    end else if (in_valid) begin
                        r_data_wr <= in_data;
                        r_addr    <= r_addr_cnt;
                        r_wren    <= c_wren_one << r_bank_cnt;
                        if (w_last_bank) begin
                            r_bank_cnt <= '0;
                            if (w_last_addr) begin
                                r_addr_cnt <= '0;
                                r_state    <= S_DONE;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                            end else begin
                                r_addr_cnt <= r_addr_cnt + c_addr_w'(1);
                            end
                        end else begin
                            r_bank_cnt <= r_bank_cnt + c_bank_w'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = (r_state == S_LOAD);
    assign data_wr         = r_data_wr;
    assign data_layer_wren = r_wren;
    assign addr            = r_addr;
    assign busy            = r_busy;
    assign done            = r_done;

`ifdef SPLIT_RAM_LOADER_CHECKSUM_EN
    logic [RAM_WIDTH-1:0] r_checksum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_checksum <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + in_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: doc/split_ram_loader.md
Name: split_ram_loader

Overview:
- Write-side companion to the banked split ROM/RAM array: `NUM_RAMS` banks, each `RAM_DEPTH` x `RAM_WIDTH`, sharing one address bus.
- Accepts a serial stream of `RAM_WIDTH` words over a valid/ready handshake.
- Drives the shared `data_wr` / `addr` buses and a one-hot per-bank write enable, filling the banks address-interleaved (bank 0..`NUM_RAMS`-1 at address 0, then address 1, ...).
- Used to preload weight/layer memories from a host or DMA stream before inference starts.

Parameters:
- `NUM_RAMS`, 8, number of banks; one-hot width of `data_layer_wren`.
- `RAM_DEPTH`, 256, words per bank; address counter wraps at `RAM_DEPTH`-1.
- `RAM_WIDTH`, 16, word width of stream and write bus.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a load from bank 0, addr 0.
- `abort`  in  1  one-cycle pulse; terminates the load in progress.
- `in_data`  in  `RAM_WIDTH`  stream word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a word this cycle.
- `data_wr`  out  `RAM_WIDTH`  write data to all banks.
- `data_layer_wren`  out  `NUM_RAMS`  one-hot bank write enable.
- `addr`  out  `$clog2(RAM_DEPTH)`  shared bank address.
- `busy`  out  1  high while in LOAD.
- `done`  out  1  one-cycle pulse after the final write is issued.

Behaviour:
- Reset (`rst`=0, asynchronous): state=IDLE; bank/addr counters=0.
  - Outputs: `data_wr`=0, `data_layer_wren`=0, `addr`=0, `in_ready`=0, `busy`=0, `done`=0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: `start`=1 → LOAD; counters cleared to 0.
  - LOAD: `in_ready`=1 combinationally. Accept occurs on `in_valid` && `in_ready`.
  - LOAD, `abort`=1 → IDLE. Abort has priority over an accept in the same cycle; that word is dropped and no write is issued.
  - LOAD, accept of word index `NUM_RAMS`*`RAM_DEPTH`-1 → DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- Write timing: registered, 1-cycle latency. On accept at cycle N, at cycle N+1:
  - `data_wr` = word.
  - `addr` = addr counter value at N.
  - `data_layer_wren` = 1 << bank counter value at N.
- `data_layer_wren`=0 in any cycle without an accept at N-1.
- `data_wr` and `addr` hold their last values when not writing.
- Counter order: bank counter increments on every accept.
  - At `NUM_RAMS`-1 it wraps to 0 and the addr counter increments.
  - At final bank/addr, both wrap to 0.
  - Word k goes to bank k mod `NUM_RAMS`, address k div `NUM_RAMS`.
- `busy`=1 exactly while state=LOAD.
- `start` while in LOAD or DONE: ignored.
- `in_valid` while not in LOAD: ignored; `in_ready`=0.
- Abort or reset mid-load: counters cleared, so a subsequent `start` reloads from word 0. Banks keep any partial contents.
- Final write's `data_layer_wren` pulse coincides with the `done` pulse (cycle after the last accept).

Optional Feature:
- Macro: `SPLIT_RAM_LOADER_CHECKSUM_EN`.
- With the macro defined:
  - Extra output port `checksum`, `RAM_WIDTH` bits: running sum modulo 2^`RAM_WIDTH` of all accepted words since `start`.
  - Cleared on reset and on `start`.
  - Registered, updated the cycle after each accept.
  - Stable and valid when `done` pulses, and held until the next `start`.
- Without the macro: no `checksum` port, no adder logic; all other behaviour identical.

Test Plan:
- Reset then idle, `in_valid`=1, `in_data`=16'hAAAA with no `start` → `in_ready`=0, `data_layer_wren`=0 throughout, `busy`=0.
- `start`, then 16 back-to-back words 0..15 (defaults) → bank k gets writes at addr 0 and addr 1:
  - `data_layer_wren`=8'h01 with `data_wr`=0, addr=0 one cycle after the first accept.
  - Word 9 → `data_layer_wren`=8'h02, addr=1.
- Full load of 2048 words with random `in_valid` gaps → exactly 2048 one-hot writes.
  - Word k lands at bank k%8, addr k/8.
  - `done` is a single pulse coincident with the write of word 2047 (bank 7, addr 255); `busy` falls the same cycle.
- `abort` asserted together with an accept at word 100 → no write for word 100, state IDLE.
  - Next `start` plus word 16'h1234 → write to bank 0, addr 0.
- `rst` asserted low mid-load (word 500) → all outputs 0 asynchronously.
  - After release and `start`, the first write goes to bank 0, addr 0.
- With `SPLIT_RAM_LOADER_CHECKSUM_EN`, load all words = 16'h0001 → `checksum`=16'h0800 at `done`.
  - Load all words = 16'hFFFF → `checksum`=16'hF800.
